// File: rtl/ddr_pll_rst_seq_pkg.sv
// Shared definitions for the DDR rPLL reset sequencer.
//   state_e : sequencer states, 3-bit encoding fixed for debug visibility
//   max_u   : helper used to size the shared cycle counter
package ddr_pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    StRstHold  = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StDdrRel   = 3'd3,
    StRun      = 3'd4,
    StFail     = 3'd5
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr_pll_rst_seq_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, synchronous reset to 0.
//   clk   : destination clock
//   rst_n : synchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output, two cycles of latency
module ddr_pll_rst_seq_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ddr_pll_rst_seq.sv
// Power-up / recovery sequencer for the DDR rPLL, clocked by the free-running board clock.
// Holds the PLL in reset, qualifies LOCK, then releases the DDR controller reset. Retries
// the PLL on lock timeout and re-sequences on lock loss.
//   sys_clk      : free-running board clock
//   sys_rst_n    : synchronous active-low reset
//   pll_lock     : rPLL LOCK, asynchronous
//   soft_rst_req : one-cycle pulse, restarts the sequence and clears failure
//   pll_reset    : rPLL RESET, active high
//   ddr_rst_n    : DDR controller reset, active low
//   clk_ready    : high only in RUN
//   pll_fail     : sticky, retries exhausted
//   retry_cnt    : retries consumed in the current sequence
module ddr_pll_rst_seq
  import ddr_pll_rst_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYC     = 1000,
  parameter int unsigned LOCK_TIMEOUT_CYC = 500000,
  parameter int unsigned LOCK_STABLE_CYC  = 4096,
  parameter int unsigned DDR_RST_DLY_CYC  = 256,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  input  logic       soft_rst_req,
  output logic       pll_reset,
  output logic       ddr_rst_n,
  output logic       clk_ready,
  output logic       pll_fail,
  output logic [1:0] retry_cnt
);

  localparam int unsigned CntMax = max_u(max_u(RST_HOLD_CYC, LOCK_TIMEOUT_CYC),
                                         max_u(LOCK_STABLE_CYC, DDR_RST_DLY_CYC));
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      retry_q, retry_d;
  logic            lock_s;

  ddr_pll_rst_seq_sync_2ff u_lock_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (soft_rst_req) begin
      state_d = StRstHold;
      retry_d = 2'd0;
    end else begin
      unique case (state_q)
        StRstHold: begin
          if (cnt_q == CntW'(RST_HOLD_CYC - 1)) state_d = StWaitLock;
        end
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStable;
          end else if (cnt_q == CntW'(LOCK_TIMEOUT_CYC - 1)) begin
            if (retry_q == 2'(MAX_RETRY)) begin
              state_d = StFail;
            end else begin
              retry_d = retry_q + 2'd1;
              state_d = StRstHold;
            end
          end
        end
        StStable: begin
          // The high sample that left WAIT_LOCK is the first of the consecutive run,
          // so STABLE itself only needs LOCK_STABLE_CYC-1 more.
          if (!lock_s) begin
            state_d = StWaitLock;
          end else if (cnt_q == CntW'(LOCK_STABLE_CYC - 2)) begin
            state_d = StDdrRel;
          end
        end
        StDdrRel: begin
          if (!lock_s) begin
            state_d = StRstHold;
          end else if (cnt_q == CntW'(DDR_RST_DLY_CYC - 1)) begin
            state_d = StRun;
            retry_d = 2'd0;
          end
        end
        StRun: begin
          // Lock loss here is a re-sequence, not a retry.
          if (!lock_s) state_d = StRstHold;
        end
        StFail: begin
          state_d = StFail;
        end
        default: begin
          state_d = StRstHold;
        end
      endcase
    end
    cnt_d = ((state_d != state_q) || soft_rst_req) ? '0 : cnt_q + CntW'(1);
  end

  // Outputs decoded from the next state so they are valid in the first cycle of each state.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= StRstHold;
      cnt_q     <= '0;
      retry_q   <= 2'd0;
      pll_reset <= 1'b1;
      ddr_rst_n <= 1'b0;
      clk_ready <= 1'b0;
      pll_fail  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_reset <= (state_d == StRstHold) || (state_d == StFail);
      ddr_rst_n <= (state_d == StRun);
      clk_ready <= (state_d == StRun);
      pll_fail  <= (state_d == StFail);
    end
  end

  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_ddr_pll_rst_seq.sv
// Self-checking bench for ddr_pll_rst_seq with shortened timing parameters.
// Expected values are queued when stimulus is applied and popped when the observation is made.
// Latencies are counted in clock edges starting from the first edge that samples the new input.
module tb_ddr_pll_rst_seq;

  localparam int unsigned RstHold  = 8;
  localparam int unsigned Timeout  = 64;
  localparam int unsigned Stable   = 16;
  localparam int unsigned DdrDly   = 4;
  localparam int unsigned MaxRetry = 2;
  localparam int          Budget   = 300;

  logic       sys_clk      = 1'b0;
  logic       sys_rst_n    = 1'b0;
  logic       pll_lock     = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       pll_reset;
  logic       ddr_rst_n;
  logic       clk_ready;
  logic       pll_fail;
  logic [1:0] retry_cnt;

  always #5 sys_clk = ~sys_clk;

  ddr_pll_rst_seq #(
    .RST_HOLD_CYC     (RstHold),
    .LOCK_TIMEOUT_CYC (Timeout),
    .LOCK_STABLE_CYC  (Stable),
    .DDR_RST_DLY_CYC  (DdrDly),
    .MAX_RETRY        (MaxRetry)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .pll_lock     (pll_lock),
    .soft_rst_req (soft_rst_req),
    .pll_reset    (pll_reset),
    .ddr_rst_n    (ddr_rst_n),
    .clk_ready    (clk_ready),
    .pll_fail     (pll_fail),
    .retry_cnt    (retry_cnt)
  );

  typedef struct {
    string tag;
    int    exp_v;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic sb_push(input string tag, input int exp_v);
    exp_t e;
    e.tag   = tag;
    e.exp_v = exp_v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp_v);
    end
  endtask

  // 0 pll_reset, 1 ddr_rst_n, 2 clk_ready, 3 pll_fail, 4 retry_cnt
  function automatic int get_out(input int sel);
    case (sel)
      0:       return (pll_reset === 1'b1) ? 1 : 0;
      1:       return (ddr_rst_n === 1'b1) ? 1 : 0;
      2:       return (clk_ready === 1'b1) ? 1 : 0;
      3:       return (pll_fail === 1'b1) ? 1 : 0;
      default: return int'(retry_cnt);
    endcase
  endfunction

  // Negedges until output sel equals val (0 if already); -1 when the budget expires.
  task automatic wait_for(input int sel, input int val, output int n);
    bit done;
    n    = 0;
    done = 0;
    while (!done) begin
      if (get_out(sel) == val) begin
        done = 1;
      end else if (n >= Budget) begin
        n    = -1;
        done = 1;
      end else begin
        @(negedge sys_clk);
        n++;
      end
    end
  endtask

  task automatic apply_reset(input string pfx, input int cycles);
    sys_rst_n    = 1'b0;
    pll_lock     = 1'b0;
    soft_rst_req = 1'b0;
    repeat (cycles) @(negedge sys_clk);
    sb_push({pfx, "_rst_pll_reset"}, 1);
    sb_push({pfx, "_rst_ddr_rst_n"}, 0);
    sb_push({pfx, "_rst_clk_ready"}, 0);
    sb_push({pfx, "_rst_pll_fail"}, 0);
    sb_push({pfx, "_rst_retry_cnt"}, 0);
    for (int s = 0; s < 5; s++) sb_pop(get_out(s));
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    int rs;
    int lo;
    int fd;

    // 1 Nominal
    apply_reset("s1", 3);
    sb_push("s1_hold_len", 8);
    wait_for(0, 0, n);
    sb_pop(n);
    repeat (10) @(negedge sys_clk);
    pll_lock = 1'b1;
    sb_push("s1_lock_to_rel", 22);
    sb_push("s1_clk_ready", 1);
    sb_push("s1_retry", 0);
    wait_for(1, 1, n);
    sb_pop(n);
    sb_pop(get_out(2));
    sb_pop(get_out(4));

    // 4 Lock loss in RUN
    pll_lock = 1'b0;
    sb_push("s4_loss_to_ddr_low", 3);
    sb_push("s4_clk_ready", 0);
    sb_push("s4_pll_reset", 1);
    sb_push("s4_hold_len", 8);
    wait_for(1, 0, n);
    sb_pop(n);
    sb_pop(get_out(2));
    sb_pop(get_out(0));
    wait_for(0, 0, n);
    sb_pop(n);

    // 2 Glitch during relock
    repeat (3) @(negedge sys_clk);
    sb_push("s2_ddr_high_in_glitch", 0);
    sb_push("s2_pll_reset_in_glitch", 0);
    hi = 0;
    rs = 0;
    pll_lock = 1'b1;
    repeat (10) begin
      @(negedge sys_clk);
      hi += get_out(1);
      rs += get_out(0);
    end
    pll_lock = 1'b0;
    repeat (5) begin
      @(negedge sys_clk);
      hi += get_out(1);
      rs += get_out(0);
    end
    sb_pop(hi);
    sb_pop(rs);
    pll_lock = 1'b1;
    sb_push("s2_lock_to_rel", 22);
    sb_push("s2_retry", 0);
    wait_for(1, 1, n);
    sb_pop(n);
    sb_pop(get_out(4));

    // 3 Timeout with lock held low
    apply_reset("s3", 2);
    for (int a = 0; a < 3; a++) begin
      sb_push($sformatf("s3_retry_%0d", a), a);
      sb_push($sformatf("s3_hold_%0d", a), 8);
      sb_pop(get_out(4));
      wait_for(0, 0, n);
      sb_pop(n);
      if (a < 2) begin
        sb_push($sformatf("s3_gap_%0d", a), 64);
        wait_for(0, 1, n);
        sb_pop(n);
      end
    end
    sb_push("s3_fail_delay", 64);
    sb_push("s3_fail_pll_reset", 1);
    sb_push("s3_fail_retry", 2);
    wait_for(3, 1, n);
    sb_pop(n);
    sb_pop(get_out(0));
    sb_pop(get_out(4));
    sb_push("s3_pll_reset_low_in_fail", 0);
    sb_push("s3_fail_dropped", 0);
    lo = 0;
    fd = 0;
    repeat (20) begin
      @(negedge sys_clk);
      lo += 1 - get_out(0);
      fd += 1 - get_out(3);
    end
    sb_pop(lo);
    sb_pop(fd);

    // 5 Soft reset recovery from FAIL
    soft_rst_req = 1'b1;
    sb_push("s5_pll_fail", 0);
    sb_push("s5_retry", 0);
    sb_push("s5_pll_reset", 1);
    @(negedge sys_clk);
    soft_rst_req = 1'b0;
    sb_pop(get_out(3));
    sb_pop(get_out(4));
    sb_pop(get_out(0));
    sb_push("s5_hold_len", 8);
    wait_for(0, 0, n);
    sb_pop(n);
    repeat (10) @(negedge sys_clk);
    pll_lock = 1'b1;
    sb_push("s5_lock_to_rel", 22);
    wait_for(1, 1, n);
    sb_pop(n);

    // 6 Reset in the middle of DDR_REL
    pll_lock = 1'b0;
    sb_push("s6_loss_to_ddr_low", 3);
    sb_push("s6_hold_len", 8);
    wait_for(1, 0, n);
    sb_pop(n);
    wait_for(0, 0, n);
    sb_pop(n);
    repeat (2) @(negedge sys_clk);
    pll_lock = 1'b1;
    sb_push("s6_ddr_low_in_ddr_rel", 0);
    repeat (19) @(negedge sys_clk);
    sb_pop(get_out(1));
    apply_reset("s6", 1);
    sb_push("s6_hold_len_after_rst", 8);
    wait_for(0, 0, n);
    sb_pop(n);
    repeat (10) @(negedge sys_clk);
    pll_lock = 1'b1;
    sb_push("s6_lock_to_rel", 22);
    wait_for(1, 1, n);
    sb_pop(n);

    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
